// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss 24-hour timekeeper with synchronised 1 Hz input and minute/hour adjust.
// Optional hourly chime counter is built when CHIME_ENABLE_EN is defined.
module bcd_time_counter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CHIME_LEN   = 4
) (
    input  logic       CLK_12,
    input  logic       nCR,
    input  logic       EN,
    input  logic       CP_1Hz,
    input  logic       Adj_Min,
    input  logic       Adj_Hour,
    output logic [7:0] Second,
    output logic [7:0] Minute,
    output logic [7:0] Hour,
    output logic       Tick,
    output logic       Chime
);

    logic [SYNC_STAGES-1:0] cp_sync;
    logic [SYNC_STAGES-1:0] min_sync;
    logic [SYNC_STAGES-1:0] hour_sync;
    logic                   cp_hist;
    logic                   min_hist;
    logic                   hour_hist;

    logic cp_edge;
    logic min_edge;
    logic hour_edge;
    logic tick_ev;
    logic sec_wrap;
    logic min_carry;
    logic min_step;
    logic hour_step;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return '0;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge CLK_12 or negedge nCR) begin
        if (!nCR) begin
            cp_sync   <= '0;
            min_sync  <= '0;
            hour_sync <= '0;
            cp_hist   <= 1'b0;
            min_hist  <= 1'b0;
            hour_hist <= 1'b0;
        end else begin
            cp_sync   <= {cp_sync[SYNC_STAGES-2:0], CP_1Hz};
            min_sync  <= {min_sync[SYNC_STAGES-2:0], Adj_Min};
            hour_sync <= {hour_sync[SYNC_STAGES-2:0], Adj_Hour};
            cp_hist   <= cp_sync[SYNC_STAGES-1];
            min_hist  <= min_sync[SYNC_STAGES-1];
            hour_hist <= hour_sync[SYNC_STAGES-1];
        end
    end

    // A coincident Adj_Min edge absorbs the tick carry, so only one minute step
    // happens and the 59->00 wrap does not propagate into Hour.
    always_comb begin
        cp_edge   = cp_sync[SYNC_STAGES-1] & ~cp_hist;
        min_edge  = min_sync[SYNC_STAGES-1] & ~min_hist;
        hour_edge = hour_sync[SYNC_STAGES-1] & ~hour_hist;
        tick_ev   = cp_edge & EN;
        sec_wrap  = tick_ev & (Second == 8'h59);
        min_carry = sec_wrap & ~min_edge & (Minute == 8'h59);
        min_step  = sec_wrap | min_edge;
        hour_step = min_carry | hour_edge;
    end

    always_ff @(posedge CLK_12 or negedge nCR) begin
        if (!nCR) begin
            Second <= '0;
            Minute <= '0;
            Hour   <= '0;
            Tick   <= 1'b0;
        end else begin
            Tick <= tick_ev;
            if (tick_ev)
                Second <= bcd_inc(Second, 8'h59);
            if (min_step)
                Minute <= bcd_inc(Minute, 8'h59);
            if (hour_step)
                Hour <= bcd_inc(Hour, 8'h23);
        end
    end

`ifdef CHIME_ENABLE_EN
    logic [3:0] chime_cnt;
    logic [3:0] chime_next;

    always_comb begin
        chime_next = chime_cnt;
        if (min_carry)
            chime_next = 4'(CHIME_LEN);
        else if (tick_ev && chime_cnt != '0)
            chime_next = chime_cnt - 4'd1;
    end

    always_ff @(posedge CLK_12 or negedge nCR) begin
        if (!nCR) begin
            chime_cnt <= '0;
            Chime     <= 1'b0;
        end else begin
            chime_cnt <= chime_next;
            Chime     <= (chime_next != '0);
        end
    end
`else
    assign Chime = 1'b0;
`endif

endmodule
